// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Requester indices double as bit positions in the Req/Ack/Grant vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_DBG  = 0;
    localparam int REQ_DATA = 1;
    localparam int REQ_IF   = 2;

    localparam int WAIT_MIN   = 1;
    localparam int WAIT_MAX   = 15;
    localparam int STARVE_MIN = 1;
    localparam int STARVE_MAX = 15;

    // Both the wait counter and the starvation counter fit in 4 bits.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority winner selection: debug > data > fetch, except that fetch
// overtakes data (never debug) once the starvation counter has hit its limit.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       starve_hit,
    output logic [2:0] winner
);

    always_comb begin
        winner = 3'b000;
        if (req[REQ_DBG]) begin
            winner[REQ_DBG] = 1'b1;
        end else if (starve_hit && req[REQ_IF]) begin
            winner[REQ_IF] = 1'b1;
        end else if (req[REQ_DATA]) begin
            winner[REQ_DATA] = 1'b1;
        end else if (req[REQ_IF]) begin
            winner[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between debug, data and fetch
// requesters; one access at a time, fixed priority with a fetch-starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_LIM  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          Req,
    input  logic [2:0]          We,
    input  logic [3*ADDR_W-1:0] Addr,
    input  logic [3*DATA_W-1:0] WData,
    output logic [2:0]          Ack,
    output logic [DATA_W-1:0]   RData,
    output logic [2:0]          Grant,
    output logic                Busy,
    output logic                MemEn,
    output logic                MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWData,
    input  logic [DATA_W-1:0]   MemRData,
    output logic [1:0]          state_dbg,
    output logic [CNT_W-1:0]    starve_dbg
);

    // Handshake: a requester raises Req[i] with We/Addr/WData and holds them
    // stable until Ack[i] pulses for one cycle; the arbiter never back-pressures
    // beyond withholding Ack, and the Ack cycle itself is not a new request.

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM       = CNT_W'(STARVE_LIM);

    arb_state_t        state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0]  starve_cnt, starve_nx;
    logic [2:0]        grant, grant_nx;
    logic              lat_we, lat_we_nx;
    logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
    logic [DATA_W-1:0] lat_wdata, lat_wdata_nx;
    logic [DATA_W-1:0] rdata, rdata_nx;

    logic [2:0]        pick_req;
    logic [2:0]        winner;
    logic              starve_hit;
    logic              arb_en;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // In DONE the finishing owner's Req is still up; mask it so it cannot re-win.
    assign pick_req   = (state == S_DONE) ? (Req & ~grant) : Req;
    assign starve_hit = (starve_cnt == LIM);

    mem_arb_pick u_pick (
        .req        (pick_req),
        .starve_hit (starve_hit),
        .winner     (winner)
    );

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (winner[i]) begin
                win_we    = We[i];
                win_addr  = Addr[i*ADDR_W +: ADDR_W];
                win_wdata = WData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        starve_nx    = starve_cnt;
        grant_nx     = grant;
        lat_we_nx    = lat_we;
        lat_addr_nx  = lat_addr;
        lat_wdata_nx = lat_wdata;
        rdata_nx     = rdata;
        arb_en       = 1'b0;

        case (state)
            S_IDLE: arb_en = 1'b1;
            S_ISSUE: begin
                if (lat_we) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx    = S_WAIT;
                    wait_cnt_nx = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    rdata_nx = MemRData;
                    state_nx = S_DONE;
                end else begin
                    wait_cnt_nx = wait_cnt - 1'b1;
                end
            end
            S_DONE: begin
                arb_en   = 1'b1;
                state_nx = S_IDLE;
                grant_nx = 3'b000;
            end
            default: state_nx = S_IDLE;
        endcase

        if (arb_en && (winner != 3'b000)) begin
            state_nx     = S_ISSUE;
            grant_nx     = winner;
            lat_we_nx    = win_we;
            lat_addr_nx  = win_addr;
            lat_wdata_nx = win_wdata;
            if (winner[REQ_IF]) begin
                starve_nx = '0;
            end else if (winner[REQ_DATA] && Req[REQ_IF] && !starve_hit) begin
                starve_nx = starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            grant      <= 3'b000;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            starve_cnt <= starve_nx;
            grant      <= grant_nx;
            lat_we     <= lat_we_nx;
            lat_addr   <= lat_addr_nx;
            lat_wdata  <= lat_wdata_nx;
            rdata      <= rdata_nx;
        end
    end

    assign Ack        = (state == S_DONE) ? grant : 3'b000;
    assign Grant      = grant;
    assign Busy       = (state != S_IDLE);
    assign MemEn      = (state == S_ISSUE);
    assign MemWe      = MemEn & lat_we;
    assign MemAddr    = lat_addr;
    assign MemWData   = lat_wdata;
    assign RData      = rdata;
    assign state_dbg  = state;
    assign starve_dbg = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/priority/reset cases, then a
// random three-requester phase scored against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WC  = 3;
    localparam int LIM = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0]      we = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [2:0]      ack, grant;
    logic [DW-1:0]   rdata;
    logic            busy, mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic [1:0]      state_dbg;
    logic [3:0]      starve_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STARVE_LIM(LIM)
    ) dut (
        .CLK(clk), .RST(rst), .Req(req), .We(we), .Addr(addr), .WData(wdata),
        .Ack(ack), .RData(rdata), .Grant(grant), .Busy(busy),
        .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
        .MemRData(mem_rdata), .state_dbg(state_dbg), .starve_dbg(starve_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'h1234_5678 : 32'hA5A5_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural memory, WC-cycle read latency ----------------
    logic [31:0] mem [64];
    bit          mem_loaded = 1'b0;
    logic        rd_v_sh [WC];
    logic [5:0]  rd_a_sh [WC];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] = init_val(i);
            mem_loaded = 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
        end
        for (int i = WC - 1; i > 0; i--) begin
            rd_v_sh[i] <= rd_v_sh[i-1];
            rd_a_sh[i] <= rd_a_sh[i-1];
        end
        rd_v_sh[0] <= mem_en && !mem_we;
        rd_a_sh[0] <= mem_addr[7:2];
    end

    // Data is only meaningful in the one cycle it is due; junk otherwise.
    always @(negedge clk)
        mem_rdata = (rd_v_sh[WC-1] === 1'b1) ? mem[rd_a_sh[WC-1]] : $urandom;

    // ---------------- scoreboard: model + monitor ----------------
    logic [100:0] iss_q [$];   // {cycle, we, addr, wdata, starve}
    logic [66:0]  ack_q [$];   // {cycle, ack onehot, rdata}
    logic [31:0]  ref_mem [64];
    bit           m_busy, mon_was = 1'b0;
    int           m_done, m_win, m_starve;
    logic [31:0]  last_rd;

    always @(negedge clk) begin : monitor
        logic [2:0]   eff;
        int           w, n;
        bit           wr;
        logic [31:0]  a, d;
        logic [100:0] ie;
        logic [66:0]  ae;
        n = cyc;
        if (mon_on) begin
            if (!mon_was) begin
                m_busy = 1'b0; m_starve = 0; last_rd = '0; m_done = -1; m_win = 0;
                for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
            end
            // Model: decide who owns the memory next whenever the port is free.
            if (!m_busy || n == m_done) begin
                eff = req;
                if (m_busy) eff[m_win] = 1'b0;
                w = -1;
                if (eff[0])                        w = 0;
                else if (eff[2] && m_starve == LIM) w = 2;
                else if (eff[1])                   w = 1;
                else if (eff[2])                   w = 2;
                if (w >= 0) begin
                    if (w == 2) m_starve = 0;
                    else if (w == 1 && req[2] && m_starve < LIM) m_starve++;
                    wr = we[w];
                    a  = addr[w*32 +: 32];
                    d  = wdata[w*32 +: 32];
                    if (wr) ref_mem[a[7:2]] = d;
                    else    last_rd = ref_mem[a[7:2]];
                    m_done = wr ? n + 2 : n + 2 + WC;
                    iss_q.push_back({32'(n + 1), wr, a, d, 4'(m_starve)});
                    ack_q.push_back({32'(m_done), 3'(1 << w), last_rd});
                    m_busy = 1'b1;
                    m_win  = w;
                end else begin
                    m_busy = 1'b0;
                end
            end
            // Monitor: compare against whatever the DUT presents this cycle.
            while (iss_q.size() > 0 && int'(iss_q[0][100:69]) < n) begin
                fail_now("memen_missing");
                void'(iss_q.pop_front());
            end
            while (ack_q.size() > 0 && int'(ack_q[0][66:35]) < n) begin
                fail_now("ack_missing");
                void'(ack_q.pop_front());
            end
            if (mem_en) begin
                if (iss_q.size() == 0) fail_now("memen_unexpected");
                else begin
                    ie = iss_q.pop_front();
                    check("memen_cycle", 64'(n), 64'(ie[100:69]));
                    check("mem_we", 64'(mem_we), 64'(ie[68]));
                    check("mem_addr", 64'(mem_addr), 64'(ie[67:36]));
                    if (ie[68]) check("mem_wdata", 64'(mem_wdata), 64'(ie[35:4]));
                    check("starve_cnt", 64'(starve_dbg), 64'(ie[3:0]));
                end
            end
            if (ack != 3'b000) begin
                if (ack_q.size() == 0) fail_now("ack_unexpected");
                else begin
                    ae = ack_q.pop_front();
                    check("ack_cycle", 64'(n), 64'(ae[66:35]));
                    check("ack_who", 64'(ack), 64'(ae[34:32]));
                    check("grant_at_ack", 64'(grant), 64'(ae[34:32]));
                    check("rdata_at_ack", 64'(rdata), 64'(ae[31:0]));
                end
            end
        end
        mon_was = mon_on;
    end

    // ---------------- driver tasks ----------------
    task automatic single_access(input int i, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, output int t_req, output int t_en,
                                 output int t_ack, output logic en_we,
                                 output logic [2:0] en_grant, output logic [2:0] ack_v);
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w; addr[i*32 +: 32] = a; wdata[i*32 +: 32] = d;
        t_req = cyc; t_en = -1; t_ack = -1; en_we = 1'bx; en_grant = 'x; ack_v = '0;
        for (int k = 0; k < 30 && t_ack < 0; k++) begin
            @(negedge clk);
            if (mem_en && t_en < 0) begin t_en = cyc; en_we = mem_we; en_grant = grant; end
            if (ack != 3'b000) begin t_ack = cyc; ack_v = ack; end
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic new_op(input int i);
        we[i]            = ($urandom_range(0, 3) == 0);
        addr[i*32 +: 32] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        wdata[i*32 +: 32] = $urandom;
        req[i]           = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int t, te, ta, n_ack, n_en, gmax;
        logic ew;
        logic [2:0] eg, av, a3;
        logic [2:0] order [3];
        int en_c [3];
        logic [31:0] rd_at [3];
        int gap [3];
        bit active [3];

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(ack), 0);
        check("rst_rdata", 64'(rdata), 0);
        check("rst_grant", 64'(grant), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_memen", 64'(mem_en), 0);
        check("rst_memwe", 64'(mem_we), 0);
        check("rst_memaddr", 64'(mem_addr), 0);
        check("rst_memwdata", 64'(mem_wdata), 0);
        check("rst_starve", 64'(starve_dbg), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single fetch read
        single_access(2, 1'b0, 32'h0000_0010, 32'h0, t, te, ta, ew, eg, av);
        check("rd_memen_cycle", 64'(te - t), 1);
        check("rd_memwe", 64'(ew), 0);
        check("rd_grant_issue", 64'(eg), 64'(3'b100));
        check("rd_ack_cycle", 64'(ta - t), 64'(2 + WC));
        check("rd_ack_who", 64'(av), 64'(3'b100));
        check("rd_rdata", 64'(rdata), 64'h1234_5678);

        // Data write
        single_access(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, t, te, ta, ew, eg, av);
        check("wr_memen_cycle", 64'(te - t), 1);
        check("wr_memwe", 64'(ew), 1);
        check("wr_ack_cycle", 64'(ta - t), 2);
        check("wr_ack_who", 64'(av), 64'(3'b010));
        check("wr_rdata_kept", 64'(rdata), 64'h1234_5678);
        check("wr_mem_content", 64'(mem[16]), 64'hDEAD_BEEF);

        // All three at once, each drops after its Ack
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0; addr[i*32 +: 32] = 32'(i * 4);
        end
        req = 3'b111;
        n_ack = 0; n_en = 0;
        for (int k = 0; k < 80 && n_ack < 3; k++) begin
            @(negedge clk);
            if (mem_en && n_en < 3) begin en_c[n_en] = cyc; n_en++; end
            a3 = ack;
            if (a3 != 3'b000) begin order[n_ack] = a3; rd_at[n_ack] = rdata; n_ack++; end
            @(posedge clk); #1;
            req = req & ~a3;
        end
        check("prio_ack_count", 64'(n_ack), 3);
        check("prio_en_count", 64'(n_en), 3);
        if (n_ack == 3 && n_en == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("prio_order", 64'(order[k]), 64'(3'b001 << k));
                check("prio_rdata", 64'(rd_at[k]), 64'(init_val(k)));
            end
            check("prio_spacing_1", 64'(en_c[1] - en_c[0]), 64'(2 + WC));
            check("prio_spacing_2", 64'(en_c[2] - en_c[1]), 64'(2 + WC));
        end
        req = 3'b000;

        // Reset during WAIT of a fetch read
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b0; addr[2*32 +: 32] = 32'h0000_000C;
        repeat (3) @(negedge clk);
        check("wait_state_before_rst", 64'(state_dbg), 2);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 0);
        check("arst_grant", 64'(grant), 0);
        check("arst_rdata", 64'(rdata), 0);
        check("arst_memen", 64'(mem_en), 0);
        check("arst_memaddr", 64'(mem_addr), 0);
        req[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arst_no_ack", 64'(ack), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        single_access(2, 1'b0, 32'h0000_000C, 32'h0, t, te, ta, ew, eg, av);
        check("post_rst_ack_cycle", 64'(ta - t), 64'(2 + WC));
        check("post_rst_ack_who", 64'(av), 64'(3'b100));
        check("post_rst_rdata", 64'(rdata), 64'(init_val(3)));

        // Random traffic scored by the monitor
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin active[i] = 1'b0; gap[i] = 0; end
        for (int ph = 0; ph < 2; ph++) begin
            gmax = (ph == 0) ? 0 : 5;
            for (int c = 0; c < 700; c++) begin
                @(negedge clk); a3 = ack;
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++) begin
                    if (active[i] && a3[i]) begin
                        active[i] = 1'b0; req[i] = 1'b0;
                        gap[i] = $urandom_range(0, gmax);
                    end
                    if (!active[i]) begin
                        if (gap[i] > 0) gap[i]--;
                        else if (ph == 0 || $urandom_range(0, 3) != 0) begin
                            new_op(i); active[i] = 1'b1;
                        end
                    end
                end
            end
        end
        // Drain outstanding requests
        for (int c = 0; c < 300 && (active[0] || active[1] || active[2]); c++) begin
            @(negedge clk); a3 = ack;
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (active[i] && a3[i]) begin active[i] = 1'b0; req[i] = 1'b0; end
        end
        if (active[0] || active[1] || active[2]) fail_now("drain_timeout");
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        check("iss_q_empty", 64'(iss_q.size()), 0);
        check("ack_q_empty", 64'(ack_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between three requesters of the multi-cycle CPU: the debug/program loader, the data-access (MEM state) path and the instruction-fetch (IF state) path. It accepts request/acknowledge handshakes and arbitrates with fixed priority plus a fetch-starvation guard. It issues one memory access at a time, waits a configurable read latency and returns read data to the winner. It sits between the control unit / IR / data-path registers and the unified memory array.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 1, memory read latency in cycles after the enable cycle; legal 1..15
- STARVE_LIM, 4, consecutive data grants while fetch waits before fetch is forced to win; legal 1..15

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- Req  in  3  request per requester, index 0 debug, 1 data, 2 fetch
- We  in  3  per-requester write enable, sampled with Req
- Addr  in  3*ADDR_W  per-requester address, slice i
- WData  in  3*DATA_W  per-requester write data, slice i
- Ack  out  3  one-cycle completion pulse per requester
- RData  out  DATA_W  read data of the last completed read
- Grant  out  3  one-hot current owner, 0 when idle
- Busy  out  1  high whenever state is not IDLE
- MemEn  out  1  memory access strobe, one cycle per access
- MemWe  out  1  memory write, valid with MemEn
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, valid WAIT_CYCLES cycles after MemEn cycle

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any Req, pick winner, latch its We/Addr/WData, set Grant, go ISSUE.
- ISSUE: MemEn=1, MemWe/MemAddr/MemWData from latch. Write -> DONE; read -> WAIT, wait counter loaded with WAIT_CYCLES-1.
- WAIT: decrement counter; when counter is 0, capture MemRData into RData and go DONE.
- DONE: Ack[winner]=1 for one cycle. If another Req pending (winner's own Req ignored this cycle), arbitrate and go ISSUE directly; else IDLE, Grant=0.
- Priority: debug > data > fetch. Exception: when StarveCnt==STARVE_LIM and fetch is requesting, fetch beats data (never debug).
- StarveCnt: +1 on each data grant while Req[2] high (saturates at STARVE_LIM); cleared on every fetch grant.
- Requester holds Req, We, Addr, WData stable until its Ack. Dropping Req early is a protocol violation; the access still completes and Ack still pulses.
- RData holds its value until the next read capture; writes do not modify it.

## Timing
- Reset values: state IDLE, Ack 0, RData 0, Grant 0, Busy 0, MemEn 0, MemWe 0, MemAddr 0, MemWData 0, StarveCnt 0, wait counter 0.
- Read: Req seen in IDLE at cycle t -> MemEn cycle t+1 -> Ack cycle t+2+WAIT_CYCLES.
- Write: Req at t -> MemEn t+1 -> Ack t+2.
- Back-to-back: next MemEn in the cycle after Ack. Read throughput is one per 2+WAIT_CYCLES cycles.
- RST mid-access: immediate return to reset values, no Ack issued. A write whose MemEn already fired counts as performed.
- Simultaneous Req on all three: debug, then data, then fetch, absent the starvation override.

## Structure
- Package mem_arb_pkg: state enum, requester index constants REQ_DBG=0, REQ_DATA=1, REQ_IF=2, and the WAIT_CYCLES/STARVE_LIM legal-range limits.
- One combinational sub-module mem_arb_pick: inputs Req mask, StarveCnt hit flag; output one-hot winner. Used by both IDLE and DONE.

## Test plan
- Single fetch read at 0x0000_0010, WAIT_CYCLES=1, memory returns 0x1234_5678 -> MemEn at t+1, Ack[2] at t+3, RData=0x1234_5678, Grant=3'b100 t+1..t+3.
- Data write 0xDEAD_BEEF to 0x40 -> one MemEn with MemWe=1 at t+1, Ack[1] at t+2, RData unchanged.
- Req=3'b111 held, each requester dropping Req after its Ack -> grant order debug, data, fetch; MemEn spacing 2+WAIT_CYCLES cycles.
- Data and fetch requesting continuously, STARVE_LIM=4 -> grant sequence D,D,D,D,F,D,D,D,D,F…; StarveCnt returns to 0 after each F.
- RST asserted during WAIT of a read -> all outputs 0 asynchronously, no Ack; after release, a new fetch read completes normally.
- WAIT_CYCLES=3 read -> Ack exactly 5 cycles after Req seen; RData equals MemRData sampled 3 cycles after MemEn.
